sim_end_monitor: RTL and testbench
==================================

Name: sim_end_monitor

Overview:
- Parametrised, synthesizable test-completion monitor for the alioth SoC simulation and FPGA-debug flows.
- Watches the fetch PC against up to NUM_WATCH "tohost" addresses and counts distinct arrivals.
- After HIT_THRESH arrivals, samples a result register (normally x3) and declares pass or fail; otherwise declares timeout.
- Sits beside alioth_soc_top, probing IFU PC and GPR read value; its status drives bench $display/$finish or FPGA LEDs.

Parameters:
- NUM_WATCH, 2, number of watch-address comparators (1..8)
- ADDR_W, 32, PC/watch address width
- CNT_W, 32, width of cycle and end-cycle counters
- HIT_THRESH, 8, distinct watch hits required to end the test (1..2^HIT_W-1)
- HIT_W, 8, hit-counter width
- TIMEOUT_BIT, 20, cycle-counter bit whose first set ends the test as timeout (< CNT_W)
- TIMEOUT_ENABLE, 1, 0 disables the timeout (JTAG/debug runs)
- PASS_VALUE, 1, result-register value meaning pass

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start_i  in  1  one-cycle pulse, IDLE->RUN
- clear_i  in  1  one-cycle pulse, any DONE state -> IDLE, clears counters
- pc_i  in  ADDR_W  current fetch PC
- pc_valid_i  in  1  pc_i meaningful this cycle
- watch_addr_i  in  NUM_WATCH*ADDR_W  watch addresses, slot k at [k*ADDR_W +: ADDR_W]
- watch_en_i  in  NUM_WATCH  per-slot enable
- result_i  in  32  result register value (x3)
- state_o  out  3  encoded FSM state
- done_o  out  1  high in PASS/FAIL/TIMEOUT
- pass_o  out  1  high in PASS
- fail_o  out  1  high in FAIL
- timeout_o  out  1  high in TIMEOUT
- cycle_cnt_o  out  CNT_W  cycles spent in RUN
- first_hit_cycle_o  out  CNT_W  cycle_cnt at first hit
- hit_cnt_o  out  HIT_W  distinct hits so far
- result_o  out  32  result_i captured at end

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; all outputs 0; last_pc 0; last_valid 0; first_hit_seen 0.
- States: IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4.
- IDLE:
  - start_i -> RUN next cycle.
  - Counters held at 0; PC ignored.
- RUN:
  - cycle_cnt increments every cycle (wraps at 2^CNT_W).
  - last_pc/last_valid register pc_i/pc_valid_i each cycle.
  - A hit this cycle requires all of: pc_valid_i; pc_i equals some enabled watch_addr slot; and (last_valid==0 or pc_i!=last_pc).
  - Multiple slots matching the same PC count as one hit.
  - On a hit, hit_cnt increments, saturating at 2^HIT_W-1.
  - On the first hit, first_hit_cycle latches the current (pre-increment) cycle_cnt.
- End test: when (hit_cnt + hit) == HIT_THRESH, the FSM moves next cycle to PASS if result_i==PASS_VALUE, else FAIL.
  - result_o captures result_i in that same cycle (sampled combinationally at the threshold hit).
- Timeout: if TIMEOUT_ENABLE and cycle_cnt[TIMEOUT_BIT]==1 -> TIMEOUT; result_o captures result_i.
- Same cycle threshold and timeout: threshold wins.
- PASS/FAIL/TIMEOUT are sticky:
  - counters freeze; outputs hold.
  - clear_i -> IDLE and zeroes counters, result_o, first_hit_cycle and hit tracking.
  - start_i is ignored in these states.
- start_i and clear_i together in IDLE: start wins. clear_i in RUN: ignored.
- rst mid-RUN: immediate return to IDLE with all state zeroed; no partial result.
- Status outputs are registered decodes of state; a hit on cycle N shows on hit_cnt_o at N+1; threshold reached on cycle N gives done_o=1 at N+1.

Optional Feature:
- SIM_END_MONITOR_PER_WATCH_EN
- Defined:
  - adds output watch_hit_cnt_o [NUM_WATCH*HIT_W], one saturating counter per slot;
  - each counter increments on every hit where its slot matched, including duplicate-address slots;
  - counters are cleared by rst/clear_i and frozen in done states.
- Undefined: port absent, no per-slot counters; core behaviour identical.

Decomposition:
- Shared package (sim_mon_pkg / defines header):
  - state encodings (SIM_MON_IDLE..SIM_MON_TIMEOUT);
  - state width 3;
  - default PASS_VALUE and TIMEOUT_BIT constants.
- Sub-module sim_watch_match: NUM_WATCH parallel comparators with enables; outputs any_match and a per-slot match vector. Instantiated once.

Test Plan:
- Basic pass: start; NUM_WATCH=2, watch0=0xA0 enabled; present pc=0xA0 on 8 separate visits (other PC between each); result_i=1 -> pass_o=1, hit_cnt_o=8, result_o=1, first_hit_cycle_o = cycle of first visit.
- Fail code: same stimulus with result_i=5 -> fail_o=1, result_o=5, pass_o=0.
- Dwell filtering: pc_i held at 0xA0 for 20 cycles, then leaves and returns -> hit_cnt_o=2.
  - Same with watch0=watch1=0xA0: still 2 (no double count).
  - Disabled slot matching: 0 hits.
- Timeout: TIMEOUT_BIT=6, no hits -> timeout_o=1 one cycle after cycle_cnt reaches 64; with TIMEOUT_ENABLE=0 stays in RUN beyond 200 cycles.
- Simultaneous: 8th hit on the same cycle cycle_cnt[TIMEOUT_BIT] sets -> PASS/FAIL, not TIMEOUT.
- Reset/clear: rst during RUN with hit_cnt=3 -> all outputs 0, state 0; clear_i in PASS -> IDLE, counters 0; start_i during PASS ignored.

Source files
------------

// File: rtl/sim_mon_pkg.sv
// Shared definitions for the simulation-end monitor.
// Contents:
//   sim_mon_state_e     - FSM state encodings (IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4)
//   STATE_W             - encoded state width
//   DEFAULT_PASS_VALUE  - result-register value meaning pass
//   DEFAULT_TIMEOUT_BIT - cycle-counter bit that ends a run as timeout
//   is_done()           - true for the three sticky end states
package sim_mon_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    SIM_MON_IDLE    = 3'd0,
    SIM_MON_RUN     = 3'd1,
    SIM_MON_PASS    = 3'd2,
    SIM_MON_FAIL    = 3'd3,
    SIM_MON_TIMEOUT = 3'd4
  } sim_mon_state_e;

  localparam logic [31:0] DEFAULT_PASS_VALUE  = 32'd1;
  localparam int          DEFAULT_TIMEOUT_BIT = 20;

  function automatic logic is_done(input sim_mon_state_e s);
    return (s == SIM_MON_PASS) || (s == SIM_MON_FAIL) || (s == SIM_MON_TIMEOUT);
  endfunction

endpackage

// File: rtl/sim_watch_match.sv
// Parallel watch-address comparators.
// Ports:
//   pc         - address under test
//   watch_addr - NUM_WATCH packed addresses, slot k at [k*ADDR_W +: ADDR_W]
//   watch_en   - per-slot enable
//   match      - per-slot match (enabled and equal)
//   any_match  - OR of match
module sim_watch_match #(
  parameter int NUM_WATCH = 2,
  parameter int ADDR_W    = 32
) (
  input  logic [ADDR_W-1:0]           pc,
  input  logic [NUM_WATCH*ADDR_W-1:0] watch_addr,
  input  logic [NUM_WATCH-1:0]        watch_en,
  output logic [NUM_WATCH-1:0]        match,
  output logic                        any_match
);

  for (genvar k = 0; k < NUM_WATCH; k++) begin : g_slot
    assign match[k] = watch_en[k] && (watch_addr[k*ADDR_W +: ADDR_W] == pc);
  end

  assign any_match = |match;

endmodule

// File: rtl/sim_end_monitor.sv
// Test-completion monitor: counts distinct fetch-PC arrivals at watch
// addresses, then samples the result register and declares PASS/FAIL, or
// declares TIMEOUT when the run-cycle counter reaches 2^TIMEOUT_BIT.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   start_i, clear_i   - IDLE->RUN pulse; DONE->IDLE pulse (clears counters)
//   pc_i, pc_valid_i   - fetch PC and its qualifier
//   watch_addr_i/en_i  - packed watch addresses and per-slot enables
//   result_i           - result register (x3)
//   state_o            - encoded FSM state
//   done/pass/fail/timeout_o - registered state decodes
//   cycle_cnt_o, first_hit_cycle_o, hit_cnt_o, result_o - run statistics
// Optional build macro SIM_END_MONITOR_PER_WATCH_EN adds watch_hit_cnt_o,
// one saturating hit counter per watch slot.
module sim_end_monitor
  import sim_mon_pkg::*;
#(
  parameter int          NUM_WATCH      = 2,
  parameter int          ADDR_W         = 32,
  parameter int          CNT_W          = 32,
  parameter int          HIT_THRESH     = 8,
  parameter int          HIT_W          = 8,
  parameter int          TIMEOUT_BIT    = DEFAULT_TIMEOUT_BIT,
  parameter int          TIMEOUT_ENABLE = 1,
  parameter logic [31:0] PASS_VALUE     = DEFAULT_PASS_VALUE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        clear_i,
  input  logic [ADDR_W-1:0]           pc_i,
  input  logic                        pc_valid_i,
  input  logic [NUM_WATCH*ADDR_W-1:0] watch_addr_i,
  input  logic [NUM_WATCH-1:0]        watch_en_i,
  input  logic [31:0]                 result_i,
  output logic [STATE_W-1:0]          state_o,
  output logic                        done_o,
  output logic                        pass_o,
  output logic                        fail_o,
  output logic                        timeout_o,
  output logic [CNT_W-1:0]            cycle_cnt_o,
  output logic [CNT_W-1:0]            first_hit_cycle_o,
  output logic [HIT_W-1:0]            hit_cnt_o,
  output logic [31:0]                 result_o
`ifdef SIM_END_MONITOR_PER_WATCH_EN
  ,
  output logic [NUM_WATCH*HIT_W-1:0]  watch_hit_cnt_o
`endif
);

  sim_mon_state_e       state, state_nxt;
  logic [CNT_W-1:0]     cycle_cnt, first_hit_cycle;
  logic [HIT_W-1:0]     hit_cnt;
  logic [ADDR_W-1:0]    last_pc;
  logic                 last_valid, first_hit_seen;
  logic [31:0]          result_q;
  logic [NUM_WATCH-1:0] match;
  logic                 any_match;
  logic                 run, hit, thresh, tmo, clr;
  logic [HIT_W:0]       hit_sum;

  sim_watch_match #(.NUM_WATCH(NUM_WATCH), .ADDR_W(ADDR_W)) u_match (
    .pc         (pc_i),
    .watch_addr (watch_addr_i),
    .watch_en   (watch_en_i),
    .match      (match),
    .any_match  (any_match)
  );

  assign run = (state == SIM_MON_RUN);
  // A PC that stays put on a watch address (stall/spin loop) counts once;
  // it must leave or go invalid before it can hit again.
  assign hit     = run && pc_valid_i && any_match && (!last_valid || (pc_i != last_pc));
  // One bit wider so a saturated counter plus a hit cannot alias the threshold.
  assign hit_sum = {1'b0, hit_cnt} + {{HIT_W{1'b0}}, hit};
  assign thresh  = run && (hit_sum == (HIT_W+1)'(HIT_THRESH));
  assign tmo     = run && (TIMEOUT_ENABLE != 0) && cycle_cnt[TIMEOUT_BIT];
  assign clr     = is_done(state) && clear_i;

  always_comb begin
    state_nxt = state;
    case (state)
      SIM_MON_IDLE: if (start_i) state_nxt = SIM_MON_RUN;
      SIM_MON_RUN: begin
        // Threshold is checked first so it beats a same-cycle timeout.
        if (thresh)   state_nxt = (result_i == PASS_VALUE) ? SIM_MON_PASS : SIM_MON_FAIL;
        else if (tmo) state_nxt = SIM_MON_TIMEOUT;
      end
      SIM_MON_PASS, SIM_MON_FAIL, SIM_MON_TIMEOUT: if (clear_i) state_nxt = SIM_MON_IDLE;
      default: state_nxt = SIM_MON_IDLE;
    endcase
  end

  // State and status flags are registered together so the flags always
  // agree with state_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SIM_MON_IDLE;
      done_o    <= 1'b0;
      pass_o    <= 1'b0;
      fail_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      done_o    <= is_done(state_nxt);
      pass_o    <= (state_nxt == SIM_MON_PASS);
      fail_o    <= (state_nxt == SIM_MON_FAIL);
      timeout_o <= (state_nxt == SIM_MON_TIMEOUT);
    end
  end

  // Counters only move in RUN; IDLE always holds zeros because every way
  // into IDLE (reset or clear) zeroes them.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cycle_cnt       <= '0;
      first_hit_cycle <= '0;
      hit_cnt         <= '0;
      last_pc         <= '0;
      last_valid      <= 1'b0;
      first_hit_seen  <= 1'b0;
      result_q        <= '0;
    end else if (run) begin
      cycle_cnt  <= cycle_cnt + CNT_W'(1);
      last_pc    <= pc_i;
      last_valid <= pc_valid_i;
      if (hit && (hit_cnt != '1)) hit_cnt <= hit_cnt + HIT_W'(1);
      if (hit && !first_hit_seen) begin
        first_hit_cycle <= cycle_cnt;
        first_hit_seen  <= 1'b1;
      end
      if (thresh || tmo) result_q <= result_i;
    end
  end

  assign state_o           = state;
  assign cycle_cnt_o       = cycle_cnt;
  assign first_hit_cycle_o = first_hit_cycle;
  assign hit_cnt_o         = hit_cnt;
  assign result_o          = result_q;

`ifdef SIM_END_MONITOR_PER_WATCH_EN
  // Every matching slot is credited, so duplicate addresses each count.
  logic [NUM_WATCH-1:0][HIT_W-1:0] slot_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      slot_cnt <= '0;
    end else if (hit) begin
      for (int k = 0; k < NUM_WATCH; k++)
        if (match[k] && (slot_cnt[k] != '1)) slot_cnt[k] <= slot_cnt[k] + HIT_W'(1);
    end
  end

  assign watch_hit_cnt_o = slot_cnt;
`else
  // Per-slot match vector has no consumer without per-slot counters.
  logic unused_match;
  assign unused_match = ^match;
`endif

endmodule

// File: tb/tb_sim_end_monitor.sv
// Directed bench for sim_end_monitor. Two instances share all stimulus:
// u_dut with a short timeout (bit 6), u_noto with the timeout disabled.
module tb_sim_end_monitor;

  logic        clk, rst, start, clear, pc_valid;
  logic [31:0] pc, res;
  logic [63:0] watch_addr;
  logic [1:0]  watch_en;

  logic [2:0]  st, n_st;
  logic        done, pass, fail, tmo, n_done, n_pass, n_fail, n_tmo;
  logic [31:0] cyc, fhc, res_out, n_cyc, n_fhc, n_res_out;
  logic [7:0]  hits, n_hits;
`ifdef SIM_END_MONITOR_PER_WATCH_EN
  logic [15:0] wh, n_wh;
`endif

  int total = 0;
  int bad   = 0;

  sim_end_monitor #(.NUM_WATCH(2), .ADDR_W(32), .CNT_W(32), .HIT_THRESH(8), .HIT_W(8),
                    .TIMEOUT_BIT(6), .TIMEOUT_ENABLE(1), .PASS_VALUE(32'd1)) u_dut (
    .clk(clk), .rst(rst), .start_i(start), .clear_i(clear), .pc_i(pc), .pc_valid_i(pc_valid),
    .watch_addr_i(watch_addr), .watch_en_i(watch_en), .result_i(res), .state_o(st),
    .done_o(done), .pass_o(pass), .fail_o(fail), .timeout_o(tmo), .cycle_cnt_o(cyc),
    .first_hit_cycle_o(fhc), .hit_cnt_o(hits), .result_o(res_out)
`ifdef SIM_END_MONITOR_PER_WATCH_EN
    , .watch_hit_cnt_o(wh)
`endif
  );

  sim_end_monitor #(.NUM_WATCH(2), .ADDR_W(32), .CNT_W(32), .HIT_THRESH(8), .HIT_W(8),
                    .TIMEOUT_BIT(6), .TIMEOUT_ENABLE(0), .PASS_VALUE(32'd1)) u_noto (
    .clk(clk), .rst(rst), .start_i(start), .clear_i(clear), .pc_i(pc), .pc_valid_i(pc_valid),
    .watch_addr_i(watch_addr), .watch_en_i(watch_en), .result_i(res), .state_o(n_st),
    .done_o(n_done), .pass_o(n_pass), .fail_o(n_fail), .timeout_o(n_tmo), .cycle_cnt_o(n_cyc),
    .first_hit_cycle_o(n_fhc), .hit_cnt_o(n_hits), .result_o(n_res_out)
`ifdef SIM_END_MONITOR_PER_WATCH_EN
    , .watch_hit_cnt_o(n_wh)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One sampled clock edge with the given PC; returns 1 time unit after it.
  task automatic tick(input logic [31:0] p, input logic v);
    pc = p; pc_valid = v;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    total++; if (st !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", st); end
    total++; if ({done, pass, fail, tmo} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {done, pass, fail, tmo}); end
    total++; if ({cyc, fhc, hits, res_out} !== '0) begin bad++; $display("FAIL reset_counters got=%0h/%0h/%0h/%0h exp=0", cyc, fhc, hits, res_out); end
  endtask

  // 8 separate visits to 0xA0 at run cycles 1,3,...,15; ends at edge of cycle 15.
  task automatic test_basic_pass();
    watch_addr = {32'hB0, 32'hA0}; watch_en = 2'b01; res = 32'd1;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      tick(32'h10, 1'b1);
      tick(32'hA0, 1'b1);
      if (i == 0) begin
        total++; if (hits !== 8'd1) begin bad++; $display("FAIL first_hit_cnt got=%0d exp=1", hits); end
      end
      if (i == 6) begin
        total++; if (done !== 1'b0) begin bad++; $display("FAIL early_done got=%b exp=0", done); end
      end
    end
    total++; if (st !== 3'd2) begin bad++; $display("FAIL pass_state got=%0d exp=2", st); end
    total++; if ({done, pass, fail, tmo} !== 4'b1100) begin bad++; $display("FAIL pass_flags got=%b exp=1100", {done, pass, fail, tmo}); end
    total++; if (hits !== 8'd8) begin bad++; $display("FAIL pass_hits got=%0d exp=8", hits); end
    total++; if (res_out !== 32'd1) begin bad++; $display("FAIL pass_result got=%0d exp=1", res_out); end
    total++; if (fhc !== 32'd1) begin bad++; $display("FAIL first_hit_cycle got=%0d exp=1", fhc); end
    total++; if (cyc !== 32'd16) begin bad++; $display("FAIL pass_cycles got=%0d exp=16", cyc); end
    tick(32'hA0, 1'b1); tick(32'h10, 1'b1); tick(32'hA0, 1'b1);
    total++; if (cyc !== 32'd16 || hits !== 8'd8) begin bad++; $display("FAIL frozen got=%0d/%0d exp=16/8", cyc, hits); end
    pulse_start();
    total++; if (st !== 3'd2) begin bad++; $display("FAIL start_in_pass got=%0d exp=2", st); end
    pulse_clear();
    total++; if (st !== 3'd0 || done !== 1'b0) begin bad++; $display("FAIL clear_state got=%0d/%b exp=0/0", st, done); end
    total++; if ({cyc, fhc, hits, res_out} !== '0) begin bad++; $display("FAIL clear_counters got=%0h/%0h/%0h/%0h exp=0", cyc, fhc, hits, res_out); end
  endtask

  task automatic test_fail_code();
    res = 32'd5;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      tick(32'h10, 1'b1);
      tick(32'hA0, 1'b1);
    end
    total++; if (st !== 3'd3) begin bad++; $display("FAIL fail_state got=%0d exp=3", st); end
    total++; if ({done, pass, fail, tmo} !== 4'b1010) begin bad++; $display("FAIL fail_flags got=%b exp=1010", {done, pass, fail, tmo}); end
    total++; if (res_out !== 32'd5) begin bad++; $display("FAIL fail_result got=%0d exp=5", res_out); end
    pulse_clear();
  endtask

  // Dwell 20 cycles on 0xA0, leave, return: exactly 2 hits.
  task automatic dwell_run();
    pulse_start();
    tick(32'h10, 1'b1);
    repeat (20) tick(32'hA0, 1'b1);
    tick(32'h10, 1'b1);
    tick(32'hA0, 1'b1);
    tick(32'h10, 1'b1);
  endtask

  task automatic test_dwell();
    res = 32'd1; watch_addr = {32'hB0, 32'hA0}; watch_en = 2'b01;
    dwell_run();
    total++; if (hits !== 8'd2) begin bad++; $display("FAIL dwell_hits got=%0d exp=2", hits); end
    total++; if (fhc !== 32'd1) begin bad++; $display("FAIL dwell_first got=%0d exp=1", fhc); end
    pulse_clear();
    total++; if (st !== 3'd1) begin bad++; $display("FAIL clear_in_run got=%0d exp=1", st); end
    pulse_reset();

    watch_addr = {32'hA0, 32'hA0}; watch_en = 2'b11;
    dwell_run();
    total++; if (hits !== 8'd2) begin bad++; $display("FAIL dup_hits got=%0d exp=2", hits); end
`ifdef SIM_END_MONITOR_PER_WATCH_EN
    total++; if (wh !== {8'd2, 8'd2}) begin bad++; $display("FAIL slot_hits got=%0h exp=0202", wh); end
`endif
    pulse_reset();

    watch_en = 2'b00;
    dwell_run();
    total++; if (hits !== 8'd0) begin bad++; $display("FAIL disabled_hits got=%0d exp=0", hits); end
    pulse_reset();

    watch_en = 2'b01;
    pulse_start();
    tick(32'h10, 1'b1); tick(32'hA0, 1'b0); tick(32'h10, 1'b1);
    total++; if (hits !== 8'd0) begin bad++; $display("FAIL invalid_pc_hits got=%0d exp=0", hits); end
    pulse_reset();
  endtask

  task automatic test_timeout();
    res = 32'd7; watch_addr = {32'hB0, 32'hA0}; watch_en = 2'b01;
    pulse_start();
    repeat (64) tick(32'h10, 1'b1);
    total++; if (st !== 3'd1 || tmo !== 1'b0 || cyc !== 32'd64) begin bad++; $display("FAIL pre_timeout got=%0d/%b/%0d exp=1/0/64", st, tmo, cyc); end
    tick(32'h10, 1'b1);
    total++; if (st !== 3'd4 || {done, pass, fail, tmo} !== 4'b1001) begin bad++; $display("FAIL timeout got=%0d/%b exp=4/1001", st, {done, pass, fail, tmo}); end
    total++; if (res_out !== 32'd7 || cyc !== 32'd65) begin bad++; $display("FAIL timeout_capture got=%0d/%0d exp=7/65", res_out, cyc); end
    repeat (145) tick(32'h10, 1'b1);
    total++; if (n_st !== 3'd1 || n_done !== 1'b0 || n_cyc !== 32'd210) begin bad++; $display("FAIL no_timeout got=%0d/%b/%0d exp=1/0/210", n_st, n_done, n_cyc); end
    total++; if (cyc !== 32'd65) begin bad++; $display("FAIL timeout_frozen got=%0d exp=65", cyc); end
    pulse_reset();
  endtask

  // 8th hit lands on the edge where cycle_cnt == 64 (bit 6 set).
  task automatic test_simultaneous();
    res = 32'd1;
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      tick(32'h10, 1'b1);
      tick(32'hA0, 1'b1);
    end
    repeat (50) tick(32'h10, 1'b1);
    tick(32'hA0, 1'b1);
    total++; if (st !== 3'd2 || tmo !== 1'b0 || pass !== 1'b1) begin bad++; $display("FAIL simultaneous got=%0d/%b/%b exp=2/0/1", st, tmo, pass); end
    total++; if (hits !== 8'd8 || cyc !== 32'd65) begin bad++; $display("FAIL simult_counts got=%0d/%0d exp=8/65", hits, cyc); end
    pulse_reset();
  endtask

  task automatic test_reset_mid_run();
    res = 32'd1;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      tick(32'h10, 1'b1);
      tick(32'hA0, 1'b1);
    end
    total++; if (hits !== 8'd3) begin bad++; $display("FAIL mid_hits got=%0d exp=3", hits); end
    pulse_reset();
    total++; if (st !== 3'd0 || {done, pass, fail, tmo} !== 4'b0) begin bad++; $display("FAIL mid_reset_state got=%0d/%b exp=0/0000", st, {done, pass, fail, tmo}); end
    total++; if ({cyc, fhc, hits, res_out} !== '0) begin bad++; $display("FAIL mid_reset_counters got=%0h/%0h/%0h/%0h exp=0", cyc, fhc, hits, res_out); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; pc = '0; pc_valid = 1'b0;
    watch_addr = '0; watch_en = '0; res = '0;
    @(posedge clk); #1;
    test_reset();
    test_basic_pass();
    test_fail_code();
    test_dwell();
    test_timeout();
    test_simultaneous();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
